// File: rtl/tx_packet_ctrl_if.sv
// Handshake bundle between the USB TX packet sequencer and its neighbours:
// request side, show-ahead TX FIFO, and the bit/byte timer + shift register.
interface tx_packet_ctrl_if #(
    parameter int LEN_W = 7
);
    logic             tx_start;
    logic [3:0]       tx_pid;
    logic [LEN_W-1:0] tx_len;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_error;

    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             fifo_rd;

    logic             byte_done;
    logic             timer_clear;
    logic             timer_count_up;
    logic             timer_pause;
    logic             load_en;
    logic [7:0]       load_data;
    logic             eop_en;

    modport master (
        input  tx_start, tx_pid, tx_len, fifo_empty, fifo_rdata, byte_done,
        output tx_busy, tx_done, tx_error, fifo_rd, timer_clear, timer_count_up,
               timer_pause, load_en, load_data, eop_en
    );

    modport slave (
        output tx_start, tx_pid, tx_len, fifo_empty, fifo_rdata, byte_done,
        input  tx_busy, tx_done, tx_error, fifo_rd, timer_clear, timer_count_up,
               timer_pause, load_en, load_data, eop_en
    );
endinterface

// File: rtl/tx_packet_ctrl.sv
// USB bulk-transfer TX packet sequencer: SYNC, PID, FIFO payload, CRC16, EOP.
// Drives the byte timer and loads the TX shift register one byte at a time.
module tx_packet_ctrl #(
    parameter int MAX_BYTES  = 64,
    parameter int LEN_W      = 7,
    parameter int EOP_CYCLES = 16,
    parameter int STALL_MAX  = 255
) (
    input  logic             clk,
    input  logic             rst,
    tx_packet_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, LD_SYNC, TX_SYNC, LD_PID, TX_PID, LD_DATA, TX_DATA,
        LD_CRC1, TX_CRC1, LD_CRC2, TX_CRC2, EOP, ABORT
    } state_e;

    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int EOP_W   = $clog2(EOP_CYCLES + 1);

    localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(MAX_BYTES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX);
    localparam logic [EOP_W-1:0]   EOP_LAST   = EOP_W'(EOP_CYCLES - 1);

    // CRC16/USB: reflected poly 0xA001, one full byte per call, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         pid_q, pid_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]        crc_q, crc_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [EOP_W-1:0]   eop_cnt_q, eop_cnt_d;

    logic               ld_fix_q, ld_fix_d;
    logic [7:0]         ld_byte_q, ld_byte_d;
    logic               count_q, count_d;
    logic               eop_q, eop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               data_ld;
    logic               data_stall;
    logic               load_en;

    // NOTE: the payload load must react to fifo_empty in the same cycle to pop a
    // show-ahead FIFO correctly, so the LD_DATA outputs are decoded from state_q
    // and the FIFO flag; every other output comes straight from a flop.
    assign data_ld    = (state_q == LD_DATA) && !bus.fifo_empty;
    assign data_stall = (state_q == LD_DATA) &&  bus.fifo_empty;
    assign load_en    = ld_fix_q || data_ld;

    assign bus.load_en        = load_en;
    assign bus.timer_clear    = load_en;
    assign bus.fifo_rd        = data_ld;
    assign bus.load_data      = data_ld ? bus.fifo_rdata : ld_byte_q;
    assign bus.timer_pause    = data_stall;
    assign bus.timer_count_up = count_q;
    assign bus.eop_en         = eop_q;
    assign bus.tx_busy        = busy_q;
    assign bus.tx_done        = done_q;
    assign bus.tx_error       = error_q;

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        stall_d    = stall_q;
        eop_cnt_d  = eop_cnt_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A done/error pulse still showing blocks the accept for that one cycle.
                if (bus.tx_start && !done_q && !error_q) begin
                    state_d    = LD_SYNC;
                    pid_d      = bus.tx_pid;
                    len_d      = (bus.tx_len > MAX_LEN) ? MAX_LEN : bus.tx_len;
                    crc_d      = 16'hFFFF;
                    byte_cnt_d = '0;
                    stall_d    = '0;
                    eop_cnt_d  = '0;
                end
            end
            LD_SYNC: state_d = TX_SYNC;
            TX_SYNC: if (bus.byte_done) state_d = LD_PID;
            LD_PID:  state_d = TX_PID;
            TX_PID:  if (bus.byte_done) state_d = (len_q == '0) ? LD_CRC1 : LD_DATA;
            LD_DATA: begin
                if (!bus.fifo_empty) begin
                    state_d    = TX_DATA;
                    crc_d      = crc16_byte(crc_q, bus.fifo_rdata);
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    stall_d    = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == STALL_LAST) state_d = ABORT;
                end
            end
            TX_DATA: if (bus.byte_done) state_d = (byte_cnt_q == len_q) ? LD_CRC1 : LD_DATA;
            LD_CRC1: state_d = TX_CRC1;
            TX_CRC1: if (bus.byte_done) state_d = LD_CRC2;
            LD_CRC2: state_d = TX_CRC2;
            TX_CRC2: begin
                if (bus.byte_done) begin
                    state_d   = EOP;
                    eop_cnt_d = '0;
                end
            end
            EOP, ABORT: begin
                if (eop_cnt_q == EOP_LAST) begin
                    state_d   = IDLE;
                    eop_cnt_d = '0;
                    stall_d   = '0;
                    done_d    = (state_q == EOP);
                    error_d   = (state_q == ABORT);
                end else begin
                    eop_cnt_d = eop_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ld_fix_d = (state_d == LD_SYNC) || (state_d == LD_PID) ||
                   (state_d == LD_CRC1) || (state_d == LD_CRC2);
        count_d  = (state_d == TX_SYNC) || (state_d == TX_PID) || (state_d == TX_DATA) ||
                   (state_d == TX_CRC1) || (state_d == TX_CRC2);
        eop_d    = (state_d == EOP) || (state_d == ABORT);
        busy_d   = (state_d != IDLE);

        case (state_d)
            LD_SYNC: ld_byte_d = 8'h80;
            LD_PID:  ld_byte_d = {~pid_d, pid_d};
            LD_CRC1: ld_byte_d = ~crc_d[7:0];
            LD_CRC2: ld_byte_d = ~crc_d[15:8];
            default: ld_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pid_q      <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            crc_q      <= 16'hFFFF;
            stall_q    <= '0;
            eop_cnt_q  <= '0;
            ld_fix_q   <= 1'b0;
            ld_byte_q  <= '0;
            count_q    <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            stall_q    <= stall_d;
            eop_cnt_q  <= eop_cnt_d;
            ld_fix_q   <= ld_fix_d;
            ld_byte_q  <= ld_byte_d;
            count_q    <= count_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Bench for tx_packet_ctrl: FIFO and byte-timer models drive the DUT, a packet-level
// model (SYNC, PID, payload, CRC16/USB, EOP) supplies the expected byte stream.
module tb_tx_packet_ctrl;
    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst;

    tx_packet_ctrl_if #(.LEN_W(7)) bus ();

    tx_packet_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte_t payload[$];
    byte_t fifo_q[$];
    byte_t got[$];

    int tcnt;
    bit bd_drv;
    bit s_rd, s_clear, s_count;
    int pops, rd_wo_load, pause_n, pause_bad, eop_run, end_eop, done_n, err_n;
    int stall_at, stall_len, stall_left;
    bit stall_used;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitted CRC16/USB of the first n payload bytes, computed bit-serially.
    function automatic logic [15:0] usb_crc(input int n);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ payload[i][b];
                r  = {1'b0, r[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
            end
        end
        return ~r;
    endfunction

    task automatic fill_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(byte_t'($urandom));
    endtask

    task automatic drive_env();
        bus.byte_done  = bd_drv;
        bus.fifo_empty = (stall_left > 0) || (fifo_q.size() == 0);
        bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic sample_phase();
        @(negedge clk);
        s_rd    = bus.fifo_rd;
        s_clear = bus.timer_clear;
        s_count = bus.timer_count_up;
        if (bus.load_en) got.push_back(bus.load_data);
        if (bus.fifo_rd) begin
            pops++;
            if (!bus.load_en) rd_wo_load++;
        end
        if (bus.timer_pause) begin
            pause_n++;
            if (bus.load_en || bus.timer_count_up) pause_bad++;
        end
        if (bus.eop_en) eop_run++;
        else begin
            if (bus.tx_done || bus.tx_error) end_eop = eop_run;
            eop_run = 0;
        end
        if (bus.tx_done)  done_n++;
        if (bus.tx_error) err_n++;
        if (bus.tx_done || bus.tx_error) bus.tx_start = 1'b0;
    endtask

    // Byte timer: byte_done fires 8 clocks after each load (7 counted clocks elapsed).
    task automatic update_phase();
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (s_clear) tcnt = 0;
        else if (s_count) tcnt++;
        if (stall_left > 0) stall_left--;
        if (bd_drv && pops == stall_at && !stall_used && stall_len > 0) begin
            stall_left = stall_len;
            stall_used = 1'b1;
        end
        bd_drv = (tcnt == 7);
        drive_env();
    endtask

    task automatic clear_monitor();
        got.delete();
        pops = 0; rd_wo_load = 0; pause_n = 0; pause_bad = 0;
        eop_run = 0; end_eop = 0; done_n = 0; err_n = 0;
    endtask

    task automatic run_packet(input string tag, input logic [3:0] pid, input logic [6:0] len,
                              input bit hold, input int st_at, input int st_len, input bit abort);
        int          n;
        int          cyc;
        int          exp_pause;
        byte_t       exp_q[$];
        logic [15:0] c;

        n = (int'(len) > 64) ? 64 : int'(len);
        fifo_q = payload;
        fifo_q.push_back(8'hEE);

        exp_q.push_back(8'h80);
        exp_q.push_back({~pid, pid});
        if (abort) begin
            for (int i = 0; i < st_at; i++) exp_q.push_back(payload[i]);
            exp_pause = 255;
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(payload[i]);
            c = usb_crc(n);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
            exp_pause = (st_len > 0 && st_at < n) ? st_len : 0;
        end

        clear_monitor();
        stall_at = st_at; stall_len = st_len; stall_left = 0; stall_used = 1'b0;
        drive_env();
        bus.tx_pid   = pid;
        bus.tx_len   = len;
        bus.tx_start = 1'b1;

        cyc = 0;
        while (done_n + err_n == 0 && cyc < 3000) begin
            sample_phase();
            update_phase();
            cyc++;
            if (!hold) bus.tx_start = 1'b0;
        end
        bus.tx_start = 1'b0;
        repeat (3) begin
            sample_phase();
            update_phase();
        end

        check({tag, " finished"}, done_n + err_n, 1);
        check({tag, " done pulses"}, done_n, abort ? 0 : 1);
        check({tag, " error pulses"}, err_n, abort ? 1 : 0);
        check({tag, " eop cycles"}, end_eop, 16);
        check({tag, " fifo pops"}, pops, abort ? st_at : n);
        check({tag, " load count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s load%0d", tag, i), got[i], exp_q[i]);
        check({tag, " pause cycles"}, pause_n, exp_pause);
        check({tag, " pause outputs"}, pause_bad, 0);
        check({tag, " rd without load"}, rd_wo_load, 0);
    endtask

    initial begin
        int cyc;

        rst = 1'b1;
        bus.tx_start = 1'b0; bus.tx_pid = '0; bus.tx_len = '0;
        tcnt = 100; bd_drv = 1'b0; s_rd = 0; s_clear = 0; s_count = 0;
        stall_at = 0; stall_len = 0; stall_left = 0; stall_used = 1'b0;
        fifo_q.delete();
        clear_monitor();
        drive_env();

        repeat (3) begin
            sample_phase();
            update_phase();
        end
        sample_phase();
        check("reset outputs", {bus.load_en, bus.fifo_rd, bus.timer_clear, bus.timer_count_up,
              bus.timer_pause, bus.eop_en, bus.tx_busy, bus.tx_done, bus.tx_error, bus.load_data}, 0);
        update_phase();
        rst = 1'b0;

        // Zero-length DATA0.
        payload.delete();
        run_packet("zero", 4'b0011, 7'd0, 1'b0, 0, 0, 1'b0);
        check("zero pid byte", got.size() > 1 ? got[1] : 8'hxx, 8'hC3);
        check("zero crc lo", got.size() > 2 ? got[2] : 8'hxx, 8'h00);
        check("zero crc hi", got.size() > 3 ? got[3] : 8'hxx, 8'h00);

        // "123456789" DATA1 with the well-known CRC16/USB check value.
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(byte_t'(8'h31 + i));
        run_packet("ascii", 4'b1011, 7'd9, 1'b0, 0, 0, 1'b0);
        check("ascii pid byte", got.size() > 1 ? got[1] : 8'hxx, 8'h4B);
        check("ascii crc lo", got.size() > 11 ? got[11] : 8'hxx, 8'hC8);
        check("ascii crc hi", got.size() > 12 ? got[12] : 8'hxx, 8'hB4);

        // 20-clock FIFO gap before byte 3 of 4.
        fill_payload(4);
        run_packet("stall20", 4'b0011, 7'd4, 1'b0, 2, 20, 1'b0);

        // Gap longer than the stall limit aborts.
        fill_payload(8);
        run_packet("abort", 4'b1011, 7'd8, 1'b0, 3, 300, 1'b1);

        // Synchronous reset in the middle of a payload byte.
        fill_payload(5);
        fifo_q = payload;
        clear_monitor();
        stall_len = 0; stall_left = 0; stall_used = 1'b0;
        drive_env();
        bus.tx_pid = 4'b0011; bus.tx_len = 7'd5; bus.tx_start = 1'b1;
        sample_phase();
        update_phase();
        bus.tx_start = 1'b0;
        cyc = 0;
        while (pops < 2 && cyc < 200) begin
            sample_phase();
            update_phase();
            cyc++;
        end
        check("rst reached data", pops, 2);
        repeat (3) begin
            sample_phase();
            update_phase();
        end
        rst = 1'b1;
        sample_phase();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        tcnt = 100; bd_drv = 1'b0; s_rd = 0; s_clear = 0; s_count = 0;
        drive_env();
        clear_monitor();
        sample_phase();
        check("mid rst outputs", {bus.load_en, bus.fifo_rd, bus.timer_clear, bus.timer_count_up,
              bus.timer_pause, bus.eop_en, bus.tx_busy, bus.tx_done, bus.tx_error, bus.load_data}, 0);
        update_phase();
        fill_payload(3);
        run_packet("after rst", 4'($urandom), 7'd3, 1'b0, 0, 0, 1'b0);

        // tx_start held high and an oversize length: one packet, clamped to 64 bytes.
        fill_payload(70);
        run_packet("clamp", 4'b0011, 7'd100, 1'b1, 0, 0, 1'b0);

        // Randomised packets with optional short stalls.
        for (int k = 0; k < 6; k++) begin
            logic [6:0] rl;
            int         n;
            int         sa;
            int         sl;
            rl = 7'($urandom_range(0, 12));
            if (k == 5) rl = 7'($urandom_range(65, 127));
            n = (int'(rl) > 64) ? 64 : int'(rl);
            fill_payload(n);
            sa = 0;
            sl = 0;
            if (n >= 2 && $urandom_range(0, 1) == 1) begin
                sa = $urandom_range(1, n - 1);
                sl = $urandom_range(1, 30);
            end
            run_packet($sformatf("rnd%0d", k), 4'($urandom), rl, 1'($urandom_range(0, 1)), sa, sl, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_packet_ctrl.md
Name: tx_packet_ctrl

Overview:
Sequencer for the USB bulk-transfer transmit path. It builds one USB data packet per request: SYNC, PID, N payload bytes pulled from the TX FIFO, CRC16 (two bytes), then EOP. It drives the bit/byte timer (count/clear/pause) and loads the TX shift register byte by byte. It sits between the SD-side FIFO and the bit-level TX timer/shift register/encoder.

Parameters:
MAX_BYTES, 64, largest payload in bytes; tx_len above this is clamped to MAX_BYTES
LEN_W, 7, width of tx_len; must satisfy 2^LEN_W > MAX_BYTES
EOP_CYCLES, 16, clocks eop_en is held (2 bit times at 8 clk/bit)
STALL_MAX, 255, consecutive FIFO-empty clocks tolerated mid-payload before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
tx_start  in  1  request to send a packet; sampled only in IDLE
tx_pid  in  4  PID nibble (DATA0=0011, DATA1=1011); latched on accept
tx_len  in  LEN_W  payload byte count; latched on accept
fifo_empty  in  1  TX FIFO empty
fifo_rdata  in  8  show-ahead FIFO head byte
fifo_rd  out  1  pop FIFO head
byte_done  in  1  one-cycle pulse from timer: last bit of current byte shifted
timer_clear  out  1  clear bit/byte timer counters
timer_count_up  out  1  enable timer counting
timer_pause  out  1  freeze shift enable during FIFO stall
load_en  out  1  load load_data into TX shift register
load_data  out  8  byte to load (LSB transmitted first)
eop_en  out  1  drive EOP on the line
tx_busy  out  1  high from accept until return to IDLE
tx_done  out  1  one-cycle pulse: packet completed normally
tx_error  out  1  one-cycle pulse: packet aborted on FIFO underflow

Behaviour:
- Reset: state IDLE; every output 0; CRC register 0xFFFF; byte and stall counters 0. rst asserted mid-packet returns to IDLE on that edge, with no done/error pulse.
- States: IDLE, LD_SYNC, TX_SYNC, LD_PID, TX_PID, LD_DATA, TX_DATA, LD_CRC1, TX_CRC1, LD_CRC2, TX_CRC2, EOP, ABORT.
- IDLE: tx_start=1 latches pid and clamped len, initialises CRC to 0xFFFF and clears byte count. Next state is LD_SYNC, and tx_busy rises on the same edge. tx_start in any other state is ignored.
- LD_x states last 1 cycle, except a stalled LD_DATA. In that cycle load_en=1 and timer_clear=1, and the next state is TX_x.
- Load bytes: SYNC load_data=0x80; PID load_data={~pid,pid}.
- TX_x: timer_count_up=1 until byte_done. On byte_done, go to the next LD state. byte_done is ignored outside TX_x states.
- Order: SYNC, PID, then DATA if len>0, else CRC1 directly.
- LD_DATA with fifo_empty=0: fifo_rd=1 and load_en=1 in the same cycle; load_data=fifo_rdata. The CRC is updated with that byte, and the byte count increments.
- LD_DATA with fifo_empty=1: stall. load_en=0, fifo_rd=0, timer_pause=1, timer_count_up=0, and the stall counter increments.
  - When the stall counter reaches STALL_MAX, go to ABORT.
  - The stall counter clears on every successful load.
- TX_DATA on byte_done: go to LD_CRC1 if byte count == len, else LD_DATA.
- CRC16/USB definition: reflected poly 0xA001, init 0xFFFF, LSB-first, 8 bits processed per load in one cycle.
- CRC bytes sent: CRC1 load_data=~crc[7:0]; CRC2 load_data=~crc[15:8].
- EOP: eop_en=1 for exactly EOP_CYCLES clocks. Then tx_done=1 for one cycle, tx_busy=0, state IDLE.
- ABORT: eop_en=1 for EOP_CYCLES clocks. Then tx_error=1 for one cycle, state IDLE. The FIFO is not popped further.
- The earliest next accept is the cycle after tx_done/tx_error.

Test Plan:
- Zero-length packet (tx_pid=0011, tx_len=0, byte_done 8 clk after each load):
  - Load sequence must be 0x80, 0xC3, 0x00, 0x00.
  - eop_en then lasts 16 clocks, then a single tx_done pulse.
  - fifo_rd never asserts.
- Payload "123456789" (FIFO 0x31..0x39, tx_pid=1011, tx_len=9):
  - Loads must be 0x80, 0x4B, 0x31..0x39, 0xC8, 0xB4.
  - Exactly 9 fifo_rd pulses.
- FIFO empty for 20 clocks before byte 3 of a 4-byte packet:
  - timer_pause=1 and load_en=0 throughout the gap.
  - The packet then resumes, with correct CRC, and completes with tx_done.
- FIFO empty for STALL_MAX clocks mid-payload:
  - Goes to ABORT: eop_en for 16 clocks, then a tx_error pulse.
  - No tx_done, and no further fifo_rd.
- rst pulsed during TX_DATA: all outputs 0 the next cycle. A new tx_start afterwards sends a fresh 0x80 SYNC.
- tx_start held high through a packet and tx_len=100: one packet only, clamped to 64 payload bytes (64 fifo_rd pulses).
